// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the multi-channel BRAM arbiter.
// Channel tags are sized for the largest supported channel count.
package bram_arb_pkg;

    localparam int MAX_CHANNELS = 16;
    localparam int CH_WIDTH     = (MAX_CHANNELS > 1) ? $clog2(MAX_CHANNELS) : 1;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int strb_width(input int dw);
        return dw / 8;
    endfunction

    typedef struct packed {
        logic                valid;
        logic [CH_WIDTH-1:0] ch;
    } rd_tag_t;

endpackage

// File: rtl/bram_arbiter_rr.sv
// Combinational round-robin arbiter with a registered priority pointer.
// The pointer moves to the winner only when the grant is taken.
module rr_arbiter
    import bram_arb_pkg::*;
#(
    parameter int N = 8,
    parameter int W = ch_width(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         accept,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx
);

    logic [W-1:0] ptr;
    logic         found;
    int           idx;

    // Scan starts one past the last winner so every channel gets a turn
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= W'(N - 1);
        end else if (accept) begin
            ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/bram_arbiter_pipelined.sv
// Fully pipelined N-channel arbiter in front of one single-port BRAM.
// Reads return in acceptance order through a tag shift pipeline.
module bram_arbiter_pipelined
    import bram_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int NUM_CHANNELS = 8,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_ENABLE = 1
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_CHANNELS-1:0]                   gpu_req_valid,
    output logic [NUM_CHANNELS-1:0]                   gpu_req_ready,
    input  logic [NUM_CHANNELS-1:0]                   gpu_req_we,
    input  logic [NUM_CHANNELS*ADDR_WIDTH-1:0]        gpu_req_addr,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]        gpu_req_wdata,
    input  logic [NUM_CHANNELS*(DATA_WIDTH/8)-1:0]    gpu_req_wstrb,
    output logic [NUM_CHANNELS-1:0]                   gpu_resp_valid,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0]        gpu_resp_data,
    output logic                                      bram_en,
    output logic [(DATA_WIDTH/8)-1:0]                 bram_we,
    output logic [ADDR_WIDTH-1:0]                     bram_addr,
    output logic [DATA_WIDTH-1:0]                     bram_din,
    input  logic [DATA_WIDTH-1:0]                     bram_dout
);

    localparam int CHW = ch_width(NUM_CHANNELS);
    localparam int SW  = strb_width(DATA_WIDTH);

    logic [NUM_CHANNELS-1:0] grant;
    logic [CHW-1:0]          gidx;
    logic                    accept;
    logic                    sel_we;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [SW-1:0]           sel_wstrb;
    rd_tag_t                 tag_q [0:READ_LATENCY];
    rd_tag_t                 done;

    rr_arbiter #(
        .N(NUM_CHANNELS),
        .W(CHW)
    ) u_arb (
        .clk      (clk),
        .reset    (reset),
        .req      (gpu_req_valid),
        .accept   (accept),
        .grant    (grant),
        .grant_idx(gidx)
    );

    assign gpu_req_ready = grant;
    assign accept        = |grant;

    always_comb begin
        sel_we    = (WRITE_ENABLE != 0) && gpu_req_we[gidx];
        sel_addr  = gpu_req_addr[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = gpu_req_wdata[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
        sel_wstrb = gpu_req_wstrb[int'(gidx)*SW +: SW];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bram_en   <= 1'b0;
            bram_we   <= '0;
            bram_addr <= '0;
            bram_din  <= '0;
        end else begin
            bram_en <= accept;
            bram_we <= (accept && sel_we) ? sel_wstrb : '0;
            if (accept) begin
                bram_addr <= sel_addr;
            end
            if (accept && sel_we) begin
                bram_din <= sel_wdata;
            end
        end
    end

    // Tag stage k lines up with the BRAM access k cycles after issue
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k <= READ_LATENCY; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0].valid <= accept && !sel_we;
            tag_q[0].ch    <= CH_WIDTH'(gidx);
            for (int k = 1; k <= READ_LATENCY; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    assign done = tag_q[READ_LATENCY];

    always_ff @(posedge clk) begin
        if (reset) begin
            gpu_resp_valid <= '0;
            gpu_resp_data  <= '0;
        end else begin
            gpu_resp_valid <= '0;
            if (done.valid) begin
                gpu_resp_valid[int'(done.ch)] <= 1'b1;
                gpu_resp_data[int'(done.ch)*DATA_WIDTH +: DATA_WIDTH] <= bram_dout;
            end
        end
    end

endmodule

// File: tb/tb_bram_arbiter_pipelined.sv
// Bench: four read-latency variants plus a read-only variant share one stimulus.
// Each instance has its own BRAM model and response scoreboard.
module tb_bram_arbiter_pipelined;

    localparam int NI = 5;
    localparam int NC = 8;
    localparam int DW = 32;
    localparam int AW = 32;

    typedef struct {
        int          base;
        int          ch;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [NC-1:0]    req_valid;
    logic [NC-1:0]    req_we;
    logic [NC*AW-1:0] req_addr;
    logic [NC*DW-1:0] req_wdata;
    logic [NC*4-1:0]  req_wstrb;
    logic [AW-1:0]    a_addr  [NC];
    logic [DW-1:0]    a_wdata [NC];
    logic [3:0]       a_strb  [NC];

    logic [NC-1:0]    rdy [NI];
    logic [NC-1:0]    rv  [NI];
    logic [NC*DW-1:0] rd  [NI];
    logic             be  [NI];
    logic [3:0]       bw  [NI];
    logic [AW-1:0]    ba  [NI];
    logic [DW-1:0]    bd  [NI];
    logic [DW-1:0]    bdo [NI];

    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    exp_t        sbq [NI][$];
    logic [31:0] shadow [256];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] initf(input int a);
        return (a == 16) ? 32'hDEADBEEF : 32'(a) * 32'h01010101;
    endfunction

    always_comb begin
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        for (int c = 0; c < NC; c++) begin
            req_addr[c*AW +: AW]  = a_addr[c];
            req_wdata[c*DW +: DW] = a_wdata[c];
            req_wstrb[c*4 +: 4]   = a_strb[c];
        end
    end

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int RL  = (g < 4) ? g + 1 : 1;
        localparam int WEN = (g < 4) ? 1 : 0;

        logic [31:0] mem [256];
        logic [31:0] dq  [RL];

        bram_arbiter_pipelined #(
            .DATA_WIDTH  (DW),
            .ADDR_WIDTH  (AW),
            .NUM_CHANNELS(NC),
            .READ_LATENCY(RL),
            .WRITE_ENABLE(WEN)
        ) u_dut (
            .clk           (clk),
            .reset         (reset),
            .gpu_req_valid (req_valid),
            .gpu_req_ready (rdy[g]),
            .gpu_req_we    (req_we),
            .gpu_req_addr  (req_addr),
            .gpu_req_wdata (req_wdata),
            .gpu_req_wstrb (req_wstrb),
            .gpu_resp_valid(rv[g]),
            .gpu_resp_data (rd[g]),
            .bram_en       (be[g]),
            .bram_we       (bw[g]),
            .bram_addr     (ba[g]),
            .bram_din      (bd[g]),
            .bram_dout     (bdo[g])
        );

        // Read-first BRAM with RL cycles from enable to data
        always @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < 256; i++) mem[i] <= initf(i);
            end else if (be[g]) begin
                dq[0] <= mem[ba[g][7:0]];
                for (int b = 0; b < 4; b++)
                    if (bw[g][b]) mem[ba[g][7:0]][8*b +: 8] <= bd[g][8*b +: 8];
            end
            for (int k = 1; k < RL; k++) dq[k] <= dq[k-1];
        end

        assign bdo[g] = dq[RL-1];

        always @(negedge clk) begin
            exp_t        e;
            logic [7:0]  ev;
            logic [31:0] ed;
            int          ech;
            ev  = '0;
            ed  = '0;
            ech = 0;
            if (sbq[g].size() > 0 && sbq[g][0].base + RL + 2 == cyc) begin
                e   = sbq[g].pop_front();
                ech = e.ch;
                ed  = e.data;
                ev  = 8'(1) << ech;
            end
            checks++;
            assert (rv[g] === ev) else begin
                errors++;
                $error("FAIL resp_valid inst%0d cyc%0d: observed %b expected %b",
                       g, cyc, rv[g], ev);
            end
            if (ev != 0) begin
                checks++;
                assert (rd[g][ech*32 +: 32] === ed) else begin
                    errors++;
                    $error("FAIL resp_data inst%0d ch%0d: observed %h expected %h",
                           g, ech, rd[g][ech*32 +: 32], ed);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int c);
        logic [7:0] a;
        logic       wr;
        a  = a_addr[c][7:0];
        wr = req_we[c];
        for (int i = 0; i < NI; i++) begin
            if (i == 4) sbq[i].push_back('{base: cyc, ch: c, data: initf(int'(a))});
            else if (!wr) sbq[i].push_back('{base: cyc, ch: c, data: shadow[a]});
        end
        if (wr)
            for (int b = 0; b < 4; b++)
                if (a_strb[c][b]) shadow[a][8*b +: 8] = a_wdata[c][8*b +: 8];
    endtask

    task automatic step(input logic [NC-1:0] v, input logic [NC-1:0] w,
                        input int exp_ch, input string tag);
        logic [NC-1:0] eg;
        req_valid = v;
        req_we    = w;
        eg        = (exp_ch < 0) ? '0 : (NC'(1) << exp_ch);
        @(negedge clk);
        for (int i = 0; i < NI; i++) chk($sformatf("%s_ready%0d", tag, i), rdy[i], eg);
        if (exp_ch >= 0) push(exp_ch);
        @(posedge clk);
        #2;
        req_valid = '0;
        req_we    = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        req_we    = '0;
        for (int i = 0; i < NI; i++) sbq[i].delete();
        for (int a = 0; a < 256; a++) shadow[a] = initf(a);
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = '0;
        req_we    = '0;
        for (int c = 0; c < NC; c++) begin
            a_addr[c]  = '0;
            a_wdata[c] = '0;
            a_strb[c]  = 4'hF;
        end
        for (int a = 0; a < 256; a++) shadow[a] = initf(a);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;

        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_en%0d", i), be[i], 0);
            chk($sformatf("rst_we%0d", i), bw[i], 0);
            chk($sformatf("rst_rv%0d", i), rv[i], 0);
            chk($sformatf("rst_rd%0d", i), rd[i], 0);
        end

        // single read from ch3
        a_addr[3] = 32'h10;
        step(8'h08, 8'h00, 3, "t1");
        chk("t1_en", be[0], 1);
        chk("t1_addr", ba[0], 32'h10);
        chk("t1_we", bw[0], 0);
        step(8'h00, 8'h00, -1, "t1idle");
        chk("t1_en_idle", be[0], 0);
        chk("t1_addr_hold", ba[0], 32'h10);
        idle(8);

        // fairness with all channels requesting
        do_reset();
        for (int c = 0; c < NC; c++) a_addr[c] = 32'h20 + c;
        for (int k = 0; k < 9; k++) begin
            step(8'hFF, 8'h00, k % NC, "t2");
            chk("t2_en", be[0], 1);
            chk("t2_addr", ba[0], 32'h20 + (k % NC));
        end
        idle(8);

        // byte-strobe write, zero-strobe write, readback
        a_addr[1]  = 32'h0;
        a_wdata[1] = 32'hAABBCCDD;
        a_strb[1]  = 4'b0101;
        step(8'h02, 8'h02, 1, "t3w");
        chk("t3_we", bw[0], 4'b0101);
        chk("t3_din", bd[0], 32'hAABBCCDD);
        chk("t3_we_ro", bw[4], 0);
        a_wdata[1] = 32'h11111111;
        a_strb[1]  = 4'b0000;
        step(8'h02, 8'h02, 1, "t3z");
        chk("t3z_en", be[0], 1);
        chk("t3z_we", bw[0], 0);
        a_strb[1] = 4'hF;
        step(8'h02, 8'h00, 1, "t3r");
        idle(8);

        // alternating back-to-back reads from ch0 and ch5
        do_reset();
        for (int k = 0; k < 12; k++) begin
            a_addr[0] = 32'h40 + k;
            a_addr[5] = 32'h80 + k;
            step(8'h21, 8'h00, (k % 2 == 0) ? 0 : 5, "t4");
        end
        idle(8);

        // reset while two reads are in flight
        do_reset();
        a_addr[1] = 32'h11;
        a_addr[2] = 32'h12;
        step(8'h06, 8'h00, 1, "t5a");
        step(8'h06, 8'h00, 2, "t5b");
        do_reset();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("t5_en%0d", i), be[i], 0);
            chk($sformatf("t5_we%0d", i), bw[i], 0);
            chk($sformatf("t5_rv%0d", i), rv[i], 0);
            chk($sformatf("t5_rd%0d", i), rd[i], 0);
        end
        idle(10);
        a_addr[0] = 32'h05;
        a_addr[7] = 32'h07;
        step(8'h81, 8'h00, 0, "t5first");
        idle(8);

        // write on the read-only variant becomes a read
        a_addr[2]  = 32'h30;
        a_wdata[2] = 32'h12345678;
        a_strb[2]  = 4'hF;
        step(8'h04, 8'h04, 2, "t6");
        chk("t6_we_ro", bw[4], 0);
        chk("t6_en_ro", be[4], 1);
        chk("t6_we_rw", bw[0], 4'hF);
        step(8'h04, 8'h00, 2, "t6r");
        idle(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bram_arbiter_pipelined.md
Name: bram_arbiter_pipelined

Overview:
Multi-channel, fully pipelined arbiter between GPU memory channels and one native single-port BRAM.
- Accepts one read or write per cycle from any channel; no idle cycles between transactions.
- BRAM read latency is configurable; writes carry byte strobes.
- Returns read data per channel with an explicit response-valid pulse.
- Sits between the GPU load/store units and the on-chip data/instruction BRAM.

Parameters:
DATA_WIDTH, 32, data bus width; multiple of 8.
ADDR_WIDTH, 32, word address width.
NUM_CHANNELS, 8, requesting channels; 1..16.
READ_LATENCY, 1, BRAM clock cycles from registered bram_en to valid bram_dout; 1..4.
WRITE_ENABLE, 1, 0 makes the block read-only.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
gpu_req_valid  in  [NUM_CHANNELS]  request present per channel
gpu_req_ready  out  [NUM_CHANNELS]  request accepted this cycle (one-hot or zero)
gpu_req_we  in  [NUM_CHANNELS]  1 = write, 0 = read
gpu_req_addr  in  ADDR_WIDTH x NUM_CHANNELS  word address
gpu_req_wdata  in  DATA_WIDTH x NUM_CHANNELS  write data
gpu_req_wstrb  in  DATA_WIDTH/8 x NUM_CHANNELS  byte enables
gpu_resp_valid  out  [NUM_CHANNELS]  read data valid, one-cycle pulse
gpu_resp_data  out  DATA_WIDTH x NUM_CHANNELS  read data, held until the next response to that channel
bram_en  out  1  BRAM enable
bram_we  out  DATA_WIDTH/8  byte write enables
bram_addr  out  ADDR_WIDTH  BRAM address
bram_din  out  DATA_WIDTH  BRAM write data
bram_dout  in  DATA_WIDTH  BRAM read data

Behaviour:
Reset values:
- bram_en, bram_we, gpu_resp_valid, gpu_resp_data: all 0.
- Priority pointer = NUM_CHANNELS-1, so channel 0 has first priority.
- Read pipeline cleared.

Arbitration:
- Combinational round-robin, starting from pointer+1 (mod NUM_CHANNELS).
- gpu_req_ready is asserted only to the winner, in the same cycle; it depends on gpu_req_valid, never on a registered grant.
- Acceptance = valid && ready at a rising edge. The pointer advances to the winner only on acceptance.
- The block is never stalled: every cycle with any valid request accepts exactly one.

Request stage (registered):
- On acceptance at edge T, during cycle T+1: bram_en=1, bram_addr = address of the accepted request.
- Write accepted (WRITE_ENABLE=1): bram_we = wstrb, bram_din = wdata.
- Read accepted: bram_we = 0.
- No acceptance: bram_en=0 and bram_we=0. bram_addr and bram_din hold their previous values.

Write rules:
- No response is generated; acceptance is the acknowledgement.
- wstrb=0 is still issued (bram_en=1, bram_we=0) and produces no response.
- WRITE_ENABLE=0: gpu_req_we is ignored, every request is a read, bram_we is tied 0.

Read pipeline:
- A shift register of READ_LATENCY+1 entries of {valid, channel}, advancing every cycle.
- Read accepted at edge T: bram_dout is sampled at the end of cycle T+1+READ_LATENCY.
- gpu_resp_valid[ch] is 1 for exactly cycle T+2+READ_LATENCY, with gpu_resp_data[ch] updated in that same cycle.
- Responses return in acceptance order. Back-to-back reads give back-to-back responses.
- A channel may have up to READ_LATENCY+1 reads outstanding. Channels must accept responses unconditionally (no response back-pressure).

Simultaneous events:
- A write following a read in the next cycle is legal; the BRAM is responsible for any read-during-write behaviour.
- A new acceptance and a response delivery in the same cycle are independent.

Reset mid-operation:
- All in-flight reads are discarded; no gpu_resp_valid is asserted after reset.
- bram_en is low in the cycle after reset is sampled.

Width rules:
- Addresses and data pass through unmodified; no address arithmetic.

Decomposition:
- Package bram_arb_pkg: CH_WIDTH = max(1, clog2(NUM_CHANNELS)), STRB_WIDTH = DATA_WIDTH/8, typedef rd_tag_t {logic valid; logic [CH_WIDTH-1:0] ch}.
- Sub-module rr_arbiter: request vector plus registered pointer in, one-hot grant and index out, pointer updated on an accept input.
- Top level: request register, tag shift pipeline, response fan-out.

Test Plan:
1. Single read, READ_LATENCY=1: ch3 reads addr 0x10, BRAM model returns 0xDEADBEEF. Accept at edge T; bram_en=1 with addr 0x10 in cycle T+1; gpu_resp_valid[3]=1 with data 0xDEADBEEF in cycle T+3 only.
2. Fairness: all 8 channels hold reads continuously after reset. Grants go 0,1,...,7,0 on consecutive cycles; one bram_en per cycle; responses arrive in that order at one per cycle.
3. Byte-strobe write then read: ch1 writes 0xAABBCCDD with wstrb=4'b0101 over 0x00000000, then reads. bram_we=4'b0101 during the write cycle; read returns 0x00BB00DD.
4. Latency sweep READ_LATENCY=1..4: back-to-back reads from ch0 and ch5 alternating. Every response arrives exactly READ_LATENCY+2 cycles after its acceptance, to the correct channel, with no drops or duplicates.
5. Reset mid-flight, READ_LATENCY=3: assert reset one cycle after two reads are accepted. No gpu_resp_valid is seen afterwards; all outputs read 0; the first post-reset grant goes to channel 0.
6. WRITE_ENABLE=0: ch2 requests with we=1 and data 0x12345678. bram_we stays 0 and a read response is returned for ch2.
